// File: rtl/mul_acc.sv
// mul_acc: multiply-accumulate back end for the array multiplier `mul`.
// Sums a programmed number of products into an ACC_W-bit accumulator and
// hands the result over a valid/ready handshake.
// Optional feature macro: MUL_ACC_SAT_EN (saturating accumulation on overflow).
module mul_acc #(
  parameter int N_BIT    = 4,
  parameter int RES_SIZE = 2 * N_BIT,
  parameter int ACC_W    = 12,
  parameter int LEN_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RES_SIZE-1:0] product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    result,
  output logic                ovf,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Widen a product to accumulator width, sign- or zero-extended by mode.
  function automatic logic [ACC_W-1:0] ext_prod(input logic [RES_SIZE-1:0] p,
                                                input logic m);
    logic fill;
    fill = m & p[RES_SIZE-1];
    return {{(ACC_W-RES_SIZE){fill}}, p};
  endfunction

  // Overflow of one add: carry out when unsigned, sign rule when signed.
  function automatic logic add_overflow(input logic m, input logic a_msb,
                                        input logic b_msb, input logic s_msb,
                                        input logic carry);
    logic o;
    if (m) begin
      o = (a_msb == b_msb) && (s_msb != a_msb);
    end else begin
      o = carry;
    end
    return o;
  endfunction

`ifdef MUL_ACC_SAT_EN
  // Clamp value: all ones when unsigned; signed max or min picked by the
  // shared operand sign (both positive overflows up, both negative down).
  function automatic logic [ACC_W-1:0] sat_value(input logic m, input logic a_msb);
    logic [ACC_W-1:0] v;
    if (!m) begin
      v = {ACC_W{1'b1}};
    end else if (a_msb) begin
      v = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      v = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return v;
  endfunction
`endif

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ACC_W-1:0]     acc_r;
  logic [ACC_W-1:0]     acc_nxt_s;
  logic [ACC_W-1:0]     ext_s;
  logic [ACC_W:0]       sum_s;
  logic                 add_ovf_s;
  logic [LEN_W-1:0]     count_r;
  logic                 mode_r;
  logic                 ovf_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 accept_s;

  // in_ready_r is high exactly while the FSM sits in ACC.
  assign accept_s = in_valid & in_ready_r;

  // Extended product, full-width sum with carry, and per-add overflow.
  always_comb begin
    ext_s     = ext_prod(product, mode_r);
    sum_s     = {1'b0, acc_r} + {1'b0, ext_s};
    add_ovf_s = add_overflow(mode_r, acc_r[ACC_W-1], ext_s[ACC_W-1],
                             sum_s[ACC_W-1], sum_s[ACC_W]);
  end

  // Next accumulator value: wrap, or clamp and hold once overflowed.
  always_comb begin
    acc_nxt_s = sum_s[ACC_W-1:0];
`ifdef MUL_ACC_SAT_EN
    if (ovf_r) begin
      acc_nxt_s = acc_r;
    end else if (add_ovf_s) begin
      acc_nxt_s = sat_value(mode_r, acc_r[ACC_W-1]);
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
`endif
  end

  // Next-state logic for the IDLE / ACC / DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len == {LEN_W{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ACC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s && (count_r == CNT_ONE)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      count_r     <= {LEN_W{1'b0}};
      mode_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ACC);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r  <= mode;
            count_r <= len;
            acc_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
          end
        end
        ACC: begin
          if (accept_s) begin
            acc_r   <= acc_nxt_s;
            ovf_r   <= ovf_r | add_ovf_s;
            count_r <= count_r - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = acc_r;
  assign ovf       = ovf_r;

endmodule
